// File: rtl/fcs_append_serial_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fcs_append_serial_if : serial frame bus into and out of the FCS  |
// | appender.                                      Revision: 1.0     |
// +------------------------------------------------------------------+
interface fcs_append_serial_if;
    logic in_valid;
    logic data_in;
    logic start_of_frame;
    logic end_of_frame;
    logic in_ready;
    logic out_valid;
    logic data_out;
    logic out_sof;
    logic out_fcs_start;
    logic out_eof;

    modport slave (
        input  in_valid, data_in, start_of_frame, end_of_frame,
        output in_ready, out_valid, data_out, out_sof, out_fcs_start, out_eof
    );

    modport master (
        output in_valid, data_in, start_of_frame, end_of_frame,
        input  in_ready, out_valid, data_out, out_sof, out_fcs_start, out_eof
    );
endinterface
`default_nettype wire

// File: rtl/fcs_append_serial.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fcs_append_serial : forwards a serial frame and appends its      |
// | Ethernet CRC-32 FCS.                           Revision: 1.0     |
// +------------------------------------------------------------------+
module fcs_append_serial (
    input  wire logic            clk,
    input  wire logic            reset_n,
    fcs_append_serial_if.slave   bus
);
    localparam logic [31:0] C_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FCS     = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_crc;
    logic [4:0]  r_fcs_cnt;
    logic        r_out_valid;
    logic        r_data_out;
    logic        r_out_sof;
    logic        r_out_fcs_start;
    logic        r_out_eof;

    logic        w_accept;
    logic        w_fb;
    logic [31:0] w_crc_base;
    logic [31:0] w_crc_next;

    assign bus.in_ready      = (r_state != ST_FCS);
    assign bus.out_valid     = r_out_valid;
    assign bus.data_out      = r_data_out;
    assign bus.out_sof       = r_out_sof;
    assign bus.out_fcs_start = r_out_fcs_start;
    assign bus.out_eof       = r_out_eof;

    assign w_accept = bus.in_valid && (r_state != ST_FCS);

    // A start-of-frame bit seeds from all ones, which also discards any open frame.
    always_comb begin
        w_crc_base = bus.start_of_frame ? 32'hFFFF_FFFF : r_crc;
        w_fb       = bus.data_in ^ w_crc_base[31];
        w_crc_next = {w_crc_base[30:0], 1'b0} ^ (w_fb ? C_POLY : 32'h0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_crc           <= 32'h0;
            r_fcs_cnt       <= 5'd0;
            r_out_valid     <= 1'b0;
            r_data_out      <= 1'b0;
            r_out_sof       <= 1'b0;
            r_out_fcs_start <= 1'b0;
            r_out_eof       <= 1'b0;
        end else begin
            r_out_valid     <= 1'b0;
            r_data_out      <= 1'b0;
            r_out_sof       <= 1'b0;
            r_out_fcs_start <= 1'b0;
            r_out_eof       <= 1'b0;
            case (r_state)
                ST_IDLE, ST_PAYLOAD: begin
                    if (w_accept && (bus.start_of_frame || r_state == ST_PAYLOAD)) begin
                        r_crc       <= w_crc_next;
                        r_out_valid <= 1'b1;
                        r_data_out  <= bus.data_in;
                        r_out_sof   <= bus.start_of_frame;
                        if (bus.end_of_frame) begin
                            r_state   <= ST_FCS;
                            r_fcs_cnt <= 5'd0;
                        end else begin
                            r_state   <= ST_PAYLOAD;
                        end
                    end
                end
                ST_FCS: begin
                    // Complemented MSB first gives the reflected FCS LSB first on the wire.
                    r_out_valid     <= 1'b1;
                    r_data_out      <= ~r_crc[31];
                    r_crc           <= {r_crc[30:0], 1'b0};
                    r_fcs_cnt       <= r_fcs_cnt + 5'd1;
                    r_out_fcs_start <= (r_fcs_cnt == 5'd0);
                    r_out_eof       <= (r_fcs_cnt == 5'd31);
                    if (r_fcs_cnt == 5'd31) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/fcs_append_serial.md
# fcs_append_serial

Serial Ethernet FCS generator for the transmit path. It accepts a frame one bit per clock, forwards each payload bit unchanged and computes CRC-32 on it. After the last payload bit it appends the 32-bit FCS, so the outgoing stream passes `fcs_check_serial` on the receive side. Its framing outputs (`out_sof` on the first bit, `out_fcs_start` on the first FCS bit) connect directly to that checker's `start_of_frame` and `end_of_frame` inputs.

## Interface
- No parameters. Polynomial is fixed: 0x04C11DB7, register initialised to all ones, complemented output.
- `clk` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `data_in` and its flags are valid this cycle.
- `data_in` input 1: payload bit, in wire order.
- `start_of_frame` input 1: qualifies the first payload bit of a frame.
- `end_of_frame` input 1: qualifies the last payload bit of a frame.
- `in_ready` output 1: block accepts input this cycle. A bit transfers when `in_valid && in_ready`.
- `out_valid` output 1: `data_out` is valid this cycle.
- `data_out` output 1: serial payload bit, then FCS bit.
- `out_sof` output 1: first payload bit on `data_out`.
- `out_fcs_start` output 1: first FCS bit on `data_out`.
- `out_eof` output 1: last FCS bit on `data_out`.

## Operation
- States:
  - IDLE: no frame open.
  - PAYLOAD: frame open, accepting payload bits.
  - FCS: emitting the 32 FCS bits.
- Counter `fcs_cnt`: 5 bits.
- CRC register `crc[31:0]`.
- In PAYLOAD, each accepted bit `d` updates the register:
  - `fb = d ^ crc[31]`
  - `crc <= {crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0)`
- Accepted bit with `start_of_frame`, in any state where `in_ready=1`:
  - Compute the update from `crc = 32'hFFFFFFFF` (not the current value).
  - State becomes PAYLOAD, or FCS if `end_of_frame` is also high.
- `start_of_frame` during PAYLOAD aborts the open frame:
  - No FCS and no `out_eof` are emitted for it.
  - The new frame starts with that bit.
- Accepted bit in PAYLOAD with `end_of_frame`: update `crc`, set `fcs_cnt=0`, go to FCS.
- Accepted bits in IDLE without `start_of_frame` are dropped, with no output.
- `end_of_frame` in IDLE without `start_of_frame` is ignored.
- FCS state, one bit per cycle regardless of `in_valid`:
  - `data_out <= ~crc[31]`, then `crc <= crc << 1`, then `fcs_cnt++`.
  - Bit 0 asserts `out_fcs_start`; bit 31 asserts `out_eof`.
  - After `fcs_cnt==31`, go to IDLE.
- `in_ready = (state != FCS)`. Input presented while `in_ready=0` is not consumed; the source must hold it.
- `in_valid=0` in PAYLOAD: `crc` is held and `out_valid=0` next cycle. Gaps do not change the FCS.
- Reset (`reset_n=0`, asynchronous, any state, including mid-FCS):
  - State IDLE; `crc`, `fcs_cnt` and all outputs go to 0 except `in_ready=1`.
  - The partial frame is lost; the next `start_of_frame` begins a clean frame.

## Timing
- Payload latency is 1 cycle: a bit accepted in cycle t appears on `data_out` at t+1, with `out_valid=1` and `out_sof` as applicable.
- `end_of_frame` accepted at cycle t:
  - FCS bits 0..31 appear at t+2..t+33.
  - `out_fcs_start` at t+2; `out_eof` at t+33.
  - `in_ready=0` during cycles t+1..t+32 and returns to 1 at t+33.
- Back-to-back: `start_of_frame` accepted at t+33 appears at t+34. There is no idle output cycle between frames.
- FCS wire order: bit 0 on the wire is bit 0 of the standard reflected CRC-32 value, i.e. LSB of the little-endian FCS first.
- All outputs are registered; `in_ready` is decoded from the state register.

## Test plan
- **Known vector:** ASCII "123456789", each byte LSB first (72 bits, `in_valid` always high).
  - `data_out` repeats the 72 bits at 1-cycle latency.
  - Then 32 FCS bits equal 32'hCBF43926, LSB first.
  - `out_fcs_start` at cycle eof+2, `out_eof` at eof+33.
- **Loopback:** random 64-byte frame into `fcs_check_serial`.
  - Wiring: `data_out`→`data_in`, `out_sof`→`start_of_frame`, `out_fcs_start`→`end_of_frame`.
  - Required: `fcs_error=0` at the end of the checker's evaluation. Flipping any single payload bit gives `fcs_error=1`.
- **Gaps:** the "123456789" vector with `in_valid` low on every other cycle. Required: identical FCS 32'hCBF43926, and `out_valid` low exactly on the gap cycles.
- **Back-to-back frames:** frame B's `start_of_frame` is held pending while `in_ready=0`.
  - B is accepted in the first cycle `in_ready=1` (A's eof+33).
  - B's first bit appears directly after A's `out_eof`, and both FCS values are correct.
- **Abort:** `start_of_frame` 10 bits into frame A, then a complete frame B.
  - No `out_eof` for A.
  - B's FCS matches B's standalone FCS; a 1-bit frame (sof and eof together) also gets a correct FCS.
- **Reset mid-FCS:** `reset_n` low at FCS bit 15.
  - All outputs are 0 and `in_ready=1` immediately, without waiting for a clock edge.
  - After release, the "123456789" vector again yields 32'hCBF43926.
